alu_cmd_queue: RTL

- Upstream issue stage for alu_top.
- Buffers operation commands {ctrl, data0, data1} in a small FIFO and drives them one at a time into the combinational ALU.
- Captures the 8-bit ALU result into an output register, together with an error flag.
- Decouples the command producer from the result consumer using valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_cmd_fifo.sv | 93 +++++++++
 rtl/alu_cmd_queue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, width and command definitions for the ALU issue path.
// The issue-time error check lives here so every user classifies commands the same way.
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    typedef struct packed {
        logic [2:0]       ctrl;
        logic [ALU_W-1:0] data0;
        logic [ALU_W-1:0] data1;
    } alu_cmd_t;

    // A command is in error when it divides by zero or carries an unassigned opcode.
    function automatic logic cmd_is_err(input alu_cmd_t cmd);
        logic err;
        case (cmd.ctrl)
            OP_ADD, OP_SUB, OP_MUL: err = 1'b0;
            OP_DIV, OP_MOD:         err = (cmd.data1 == {ALU_W{1'b0}});
            default:                err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with a registered head entry.
// The head register keeps its last value once the FIFO runs empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  alu_cmd_t         din_i,
    input  logic             pop_i,
    output alu_cmd_t         head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    alu_cmd_t         mem_r [DEPTH];
    alu_cmd_t         head_r;
    alu_cmd_t         head_nxt_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    assign push_s  = push_i && !full_r;
    assign pop_s   = pop_i && !empty_r;
    assign head_o  = head_r;
    assign full_o  = full_r;
    assign empty_o = empty_r;
    assign count_o = count_r;

    // Next occupancy, read pointer and head entry; a push into an empty (or draining) FIFO becomes the head directly.
    always_comb begin
        count_nxt_s = count_r;
        rd_nxt_s    = rd_ptr_r;
        head_nxt_s  = head_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        if (count_nxt_s == CNT_W'(0)) begin
            head_nxt_s = head_r;
        end else if ((count_r == CNT_W'(0)) || ((count_r == CNT_W'(1)) && pop_s)) begin
            head_nxt_s = din_i;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            head_r   <= '0;
        end else begin
            rd_ptr_r <= rd_nxt_s;
            wr_ptr_r <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r  <= (count_nxt_s == CNT_W'(0));
            head_r   <= head_nxt_s;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din_i;
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage for alu_top: queues commands, drives the head into the ALU and registers result/error.
// Optional macro ALU_CMD_QUEUE_STATS_EN adds saturating issue and error counters.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ALU_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_ctrl_i,
    input  logic [WIDTH-1:0] cmd_data0_i,
    input  logic [WIDTH-1:0] cmd_data1_i,
    output logic [2:0]       alu_ctrl_o,
    output logic [WIDTH-1:0] alu_data0_o,
    output logic [WIDTH-1:0] alu_data1_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_err_o
`ifdef ALU_CMD_QUEUE_STATS_EN
    ,
    output logic [15:0]      stat_ops_o,
    output logic [15:0]      stat_errs_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} res_state_t;

    res_state_t       state_r;
    res_state_t       state_nxt_s;
    alu_cmd_t         cmd_in_s;
    alu_cmd_t         head_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             issue_s;
    logic             head_err_s;
    logic [WIDTH-1:0] res_data_r;
    logic             res_err_r;

    assign cmd_in_s    = '{ctrl: cmd_ctrl_i, data0: cmd_data0_i, data1: cmd_data1_i};
    assign cmd_ready_o = (fifo_count_s != CNT_W'(DEPTH));
    assign alu_ctrl_o  = head_s.ctrl;
    assign alu_data0_o = head_s.data0;
    assign alu_data1_o = head_s.data1;
    assign res_valid_o = (state_r == S_FULL);
    assign res_data_o  = res_data_r;
    assign res_err_o   = res_err_r;
    assign head_err_s  = cmd_is_err(head_s);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i && !fifo_full_s),
        .din_i   (cmd_in_s),
        .pop_i   (issue_s),
        .head_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Issue decision and output-register next state; a drain and an issue in one cycle keep it FULL.
    always_comb begin
        issue_s     = 1'b0;
        state_nxt_s = state_r;
        if (!fifo_empty_s && ((state_r == S_EMPTY) || res_ready_i)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        case (state_r)
            S_EMPTY: state_nxt_s = issue_s ? S_FULL : S_EMPTY;
            S_FULL: begin
                if (issue_s) begin
                    state_nxt_s = S_FULL;
                end else if (res_ready_i) begin
                    state_nxt_s = S_EMPTY;
                end else begin
                    state_nxt_s = S_FULL;
                end
            end
            default: state_nxt_s = S_EMPTY;
        endcase
    end

    // Output register: the ALU result is captured only on issue, and zeroed for erroring commands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= S_EMPTY;
            res_data_r <= {WIDTH{1'b0}};
            res_err_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (issue_s) begin
                res_data_r <= head_err_s ? {WIDTH{1'b0}} : alu_result_i;
                res_err_r  <= head_err_s;
            end else begin
                res_data_r <= res_data_r;
                res_err_r  <= res_err_r;
            end
        end
    end

`ifdef ALU_CMD_QUEUE_STATS_EN
    logic [15:0] stat_ops_r;
    logic [15:0] stat_errs_r;

    assign stat_ops_o  = stat_ops_r;
    assign stat_errs_o = stat_errs_r;

    // Saturating issue and error counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_ops_r  <= 16'h0000;
            stat_errs_r <= 16'h0000;
        end else if (issue_s) begin
            if (stat_ops_r != 16'hFFFF) begin
                stat_ops_r <= stat_ops_r + 16'd1;
            end
            if (head_err_s && (stat_errs_r != 16'hFFFF)) begin
                stat_errs_r <= stat_errs_r + 16'd1;
            end
        end
    end
`endif

endmodule
